// File: rtl/bram_port_initiator.sv
// Request/response initiator for one block-RAM port; credit-gated issue, FIFO-buffered read returns.
// Read latency 2 cycles (accept -> RSP_VALID). REQ_READY drops when queued + in-flight hits RSP_DEPTH.
// Build option BRAM_INIT_WRITE_ACK_EN: writes also return an ordered response tagged by RSP_IS_WRITE.
module bram_port_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          REQ_VALID,
  output logic                          REQ_READY,
  input  logic                          REQ_WE,
  input  logic [ADDR_WIDTH-1:0]         REQ_ADDR,
  input  logic [DATA_WIDTH-1:0]         REQ_DATA,
  output logic                          RSP_VALID,
  input  logic                          RSP_READY,
  output logic [DATA_WIDTH-1:0]         RSP_DATA,
  output logic                          RAM_EN,
  output logic                          RAM_WE,
  output logic [ADDR_WIDTH-1:0]         RAM_ADDR,
  output logic [DATA_WIDTH-1:0]         RAM_DI,
  input  logic [DATA_WIDTH-1:0]         RAM_DO,
  input  logic                          RAM_DO_VALID,
  output logic [$clog2(RSP_DEPTH):0]    OUTSTANDING,
  output logic                          ERR_UNEXPECTED
`ifdef BRAM_INIT_WRITE_ACK_EN
  ,
  output logic                          RSP_IS_WRITE
`endif
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
`ifdef BRAM_INIT_WRITE_ACK_EN
  localparam int EW = DATA_WIDTH + 1;
`else
  localparam int EW = DATA_WIDTH;
`endif

  logic [EW-1:0] mem [RSP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          rd_inflight;
  logic          guard;
  logic          any_inflight;
  logic          accept;
  logic          push;
  logic          pop;
  logic [EW-1:0] push_entry;

`ifdef BRAM_INIT_WRITE_ACK_EN
  logic                  wr_inflight;
  logic [DATA_WIDTH-1:0] wr_data;

  // Only one request is accepted per cycle, so read and write pushes never collide.
  assign any_inflight = rd_inflight | wr_inflight;
  assign push         = (RAM_DO_VALID && rd_inflight) || wr_inflight;
  assign push_entry   = wr_inflight ? {1'b1, wr_data} : {1'b0, RAM_DO};
  assign RSP_IS_WRITE = mem[rd_ptr][DATA_WIDTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_inflight <= 1'b0;
      wr_data     <= '0;
    end else begin
      wr_inflight <= accept && REQ_WE;
      wr_data     <= REQ_DATA;
    end
  end
`else
  assign any_inflight = rd_inflight;
  assign push         = RAM_DO_VALID && rd_inflight;
  assign push_entry   = RAM_DO;
`endif

  assign OUTSTANDING = count + CW'(any_inflight);
  assign REQ_READY   = !RST && (OUTSTANDING < CW'(RSP_DEPTH));
  assign accept      = REQ_VALID && REQ_READY;

  assign RAM_EN   = accept;
  assign RAM_WE   = accept && REQ_WE;
  assign RAM_ADDR = REQ_ADDR;
  assign RAM_DI   = REQ_DATA;

  assign RSP_VALID = (count != '0);
  assign RSP_DATA  = mem[rd_ptr][DATA_WIDTH-1:0];
  assign pop       = RSP_VALID && RSP_READY;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      rd_inflight    <= 1'b0;
      guard          <= 1'b1;
      ERR_UNEXPECTED <= 1'b0;
    end else begin
      guard       <= 1'b0;
      rd_inflight <= accept && !REQ_WE;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      // A DO_VALID in the first cycle after reset belongs to a pre-reset read.
      if (RAM_DO_VALID && !rd_inflight && !guard) begin
        ERR_UNEXPECTED <= 1'b1;
      end
    end
  end

  a_no_overflow : assert property (@(posedge CLK) disable iff (RST)
    !(push && !pop && (count == CW'(RSP_DEPTH))));

endmodule

// File: doc/bram_port_initiator.md
Name: bram_port_initiator

Overview:
Initiator for one port of the single-cycle true dual-port block RAM. It converts a valid/ready request stream of reads and writes into the RAM's EN/WE/ADDR/DI port signals. It captures each DO/DO_VALID read result into a small response FIFO and returns it on a valid/ready response stream. Credit accounting means no read result is ever lost, even when the consumer applies backpressure. Unit-test benches use one instance per RAM port.

Parameters:
DATA_WIDTH, 32, width of RAM words, REQ_DATA and RSP_DATA
ADDR_WIDTH, 10, RAM address width
RSP_DEPTH, 4, response FIFO entries; power of 2, >=2

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
REQ_VALID  in  1  request offered
REQ_READY  out  1  request accepted this cycle when high with REQ_VALID
REQ_WE  in  1  1=write, 0=read
REQ_ADDR  in  ADDR_WIDTH  request address
REQ_DATA  in  DATA_WIDTH  write data
RSP_VALID  out  1  response available
RSP_READY  in  1  consumer takes response
RSP_DATA  out  DATA_WIDTH  read data (head of FIFO)
RAM_EN  out  1  to RAM EN
RAM_WE  out  1  to RAM WE
RAM_ADDR  out  ADDR_WIDTH  to RAM ADDR
RAM_DI  out  DATA_WIDTH  to RAM DI
RAM_DO  in  DATA_WIDTH  from RAM DO
RAM_DO_VALID  in  1  from RAM DO_VALID
OUTSTANDING  out  $clog2(RSP_DEPTH)+1  FIFO count plus in-flight reads
ERR_UNEXPECTED  out  1  sticky: DO_VALID seen with no read in flight

Behaviour:
- One clock CLK; RST asynchronous, active-high. While RST is high: FIFO pointers/count=0, inflight=0, ERR_UNEXPECTED=0, guard=1, REQ_READY=0, RSP_VALID=0, RAM_EN=0.
- Credit rule: REQ_READY = !RST && (count + inflight) < RSP_DEPTH. REQ_READY is independent of REQ_VALID and REQ_WE. Writes also need a free credit (keeps ordering simple).
- Issue path is combinational pass-through. accept = REQ_VALID && REQ_READY.
  - RAM_EN = accept; RAM_WE = accept && REQ_WE.
  - RAM_ADDR = REQ_ADDR; RAM_DI = REQ_DATA (don't-care when RAM_EN=0).
- inflight register: set to 1 on an accepted read, else 0. At most one read is in flight per cycle; back-to-back reads are allowed.
- Capture: when RAM_DO_VALID && inflight, push RAM_DO into the FIFO at the end of that cycle.
  - Read latency: accept in cycle N, RAM_DO_VALID in N+1, RSP_VALID first high in N+2.
- Pop: RSP_VALID && RSP_READY advances the head. RSP_VALID = count != 0. RSP_DATA is registered FIFO head and stays stable while RSP_VALID && !RSP_READY.
- Simultaneous push and pop: count is unchanged and pointers both advance. Also legal when full.
- Full: the credit rule guarantees a push never occurs when count == RSP_DEPTH and no pop is happening. Overflow is unreachable; assert this in simulation.
- Wrap-around: pointers are ADDR-width log2(RSP_DEPTH) and wrap naturally.
- OUTSTANDING = count + inflight, combinational from registers.
- ERR_UNEXPECTED: sets on RAM_DO_VALID && !inflight && !guard; cleared only by RST.
- guard: 1 during reset, cleared on the first CLK edge after RST deasserts. A RAM_DO_VALID from a read issued before reset is then discarded silently.
- Reset mid-operation: pending FIFO contents and any in-flight read are dropped. No response for them is produced after reset.
- Write-to-read ordering: a read issued the cycle after a write to the same address returns the new data. This relies on the RAM's write-first semantics; the initiator adds nothing.

Optional Feature:
BRAM_INIT_WRITE_ACK_EN
- Defined: every accepted write also generates a response entry in request order. The entry is pushed one cycle after accept (write-inflight register, not RAM_DO_VALID), so latency is 2 cycles, as for reads.
  - Adds output RSP_IS_WRITE (1 bit, FIFO-carried); RSP_DATA = written data.
  - inflight counts reads and writes.
  - ERR_UNEXPECTED still considers read-inflight only.
- Undefined: writes produce no response, the RSP_IS_WRITE port is absent, and writes still consume a credit only in the issue cycle (inflight stays 0 for writes).

Test Plan:
- Reset then write 0xDEADBEEF @0x005, read @0x005, RSP_READY=1. Required: RSP_VALID exactly 2 cycles after read accept, RSP_DATA=0xDEADBEEF, OUTSTANDING returns to 0.
- Write 0x00000000..0x00000007 @0..7, then 8 back-to-back reads with RSP_READY=0. Required:
  - REQ_READY drops after 4 reads (RSP_DEPTH=4); OUTSTANDING=4.
  - Raising RSP_READY drains 0,1,2,3; then reads 4..7 complete in order with no loss.
- Full FIFO with RSP_READY=1 and REQ_VALID=1 reads continuously. Required: sustained one response per cycle, count constant, no overflow assertion; pointers wrap at least 3 times.
- Drive RAM_DO_VALID=1 with no read issued (guard clear). Required: ERR_UNEXPECTED=1 next cycle and it stays 1 until RST.
- Assert RST one cycle after a read accept with 2 entries queued. Required:
  - During reset: RSP_VALID=0, REQ_READY=0.
  - After release: the stale DO_VALID is ignored, ERR_UNEXPECTED=0, OUTSTANDING=0.
- With BRAM_INIT_WRITE_ACK_EN: write 0x12345678 @0x3FF then read @0x3FF. Required: two responses in order, (RSP_IS_WRITE=1, 0x12345678) then (RSP_IS_WRITE=0, 0x12345678).
